// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and long-latency (mul/div)
// interlocks, plus a watchdog on the outstanding long operation.
module pipeline_hazard_unit #(
  parameter int unsigned NSRC         = 2,
  parameter int unsigned LONG_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [5*NSRC-1:0]    ex_rs,
  input  logic [NSRC-1:0]      ex_rs_used,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_write_reg,
  input  logic                 ex_long,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_write_reg,
  input  logic                 mem_read_mem,
  input  logic [4:0]           wb_rd,
  input  logic                 wb_write_reg,
  input  logic                 long_done,
  input  logic                 mem_stall,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 long_busy,
  output logic [4:0]           busy_rd,
  output logic                 long_timeout
);

  localparam int unsigned RW = 5;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = $clog2(LONG_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LONG_TIMEOUT);

  localparam logic [SW-1:0] SEL_RF   = 2'd0;
  localparam logic [SW-1:0] SEL_MEM  = 2'd1;
  localparam logic [SW-1:0] SEL_WB   = 2'd2;
  localparam logic [SW-1:0] SEL_LONG = 2'd3;

  typedef enum logic {
    IDLE      = 1'b0,
    LONG_BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NSRC-1:0] live;
  logic            load_use;
  logic            raw_hit;
  logic            waw_hit;
  logic            long_stall;
  logic            issue;

  assign long_busy = (state == LONG_BUSY);

  // Per-operand forwarding select and load-use / RAW-on-long detection
  always_comb begin
    fwd_sel  = '0;
    live     = '0;
    load_use = 1'b0;
    raw_hit  = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      live[i] = ex_rs_used[i] && (ex_rs[RW*i +: RW] != '0);
      if (live[i] && mem_write_reg && (mem_rd == ex_rs[RW*i +: RW])) begin
        // A pending load cannot be forwarded from EX/MEM; after the bubble it sits in MEM/WB
        if (ex_valid && mem_read_mem) begin
          load_use             = 1'b1;
          fwd_sel[SW*i +: SW]  = SEL_WB;
        end else begin
          fwd_sel[SW*i +: SW]  = SEL_MEM;
        end
      end else if (live[i] && wb_write_reg && (wb_rd == ex_rs[RW*i +: RW])) begin
        fwd_sel[SW*i +: SW] = SEL_WB;
      end else if (live[i] && long_done && long_busy && (busy_rd == ex_rs[RW*i +: RW])) begin
        fwd_sel[SW*i +: SW] = SEL_LONG;
      end
      if (live[i] && (busy_rd == ex_rs[RW*i +: RW])) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign waw_hit    = ex_write_reg && (ex_rd == busy_rd) && (busy_rd != '0);
  assign long_stall = long_busy && ex_valid &&
                      ((raw_hit && !long_done) || waw_hit || (ex_long && !long_done));
  assign stall      = mem_stall || load_use || long_stall;
  assign issue      = ex_valid && ex_long && !stall;

  // Long-op tracker: destination, elapsed cycles and sticky watchdog flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy_rd      <= '0;
      cnt          <= '0;
      long_timeout <= 1'b0;
    end else begin
      if (issue) begin
        state   <= LONG_BUSY;
        busy_rd <= ex_rd;
        cnt     <= '0;
      end else if (state == LONG_BUSY) begin
        if (long_done) begin
          state   <= IDLE;
          busy_rd <= '0;
          cnt     <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
          if ((cnt + CW'(1)) == CNT_MAX) begin
            long_timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed scenarios plus a randomized run
// checked against a behavioural model of the hazard rules.
module tb_pipeline_hazard_unit;

  localparam int NSRC = 2;
  localparam int LT   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [9:0]  ex_rs;
  logic [1:0]  ex_rs_used;
  logic [4:0]  ex_rd;
  logic        ex_write_reg;
  logic        ex_long;
  logic [4:0]  mem_rd;
  logic        mem_write_reg;
  logic        mem_read_mem;
  logic [4:0]  wb_rd;
  logic        wb_write_reg;
  logic        long_done;
  logic        mem_stall;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        long_busy;
  logic [4:0]  busy_rd;
  logic        long_timeout;

  int tests = 0;
  int fails = 0;

  // Model state
  bit         m_busy;
  logic [4:0] m_rd;
  int         m_cnt;
  bit         m_to;
  logic [3:0] e_fwd;
  bit         e_stall;

  pipeline_hazard_unit #(.NSRC(NSRC), .LONG_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
    .ex_rd(ex_rd), .ex_write_reg(ex_write_reg), .ex_long(ex_long),
    .mem_rd(mem_rd), .mem_write_reg(mem_write_reg), .mem_read_mem(mem_read_mem),
    .wb_rd(wb_rd), .wb_write_reg(wb_write_reg), .long_done(long_done),
    .mem_stall(mem_stall), .fwd_sel(fwd_sel), .stall(stall), .long_busy(long_busy),
    .busy_rd(busy_rd), .long_timeout(long_timeout)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ex_valid = 0; ex_rs = '0; ex_rs_used = '0; ex_rd = '0; ex_write_reg = 0; ex_long = 0;
    mem_rd = '0; mem_write_reg = 0; mem_read_mem = 0; wb_rd = '0; wb_write_reg = 0;
    long_done = 0; mem_stall = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    next_cycle();
    next_cycle();
    rst = 1;
    m_busy = 0; m_rd = '0; m_cnt = 0; m_to = 0;
    #1;
  endtask

  // Spec rules: forwarding priority and combined stall for the current inputs
  task automatic model_comb();
    bit lu, raw;
    logic [4:0] rs;
    bit u;
    int sel;
    e_fwd = '0; lu = 0; raw = 0;
    for (int i = 0; i < NSRC; i++) begin
      rs  = ex_rs[5*i +: 5];
      u   = ex_rs_used[i] && (rs != 0);
      sel = 0;
      if (u && mem_write_reg && mem_rd == rs) begin
        if (ex_valid && mem_read_mem) begin sel = 2; lu = 1; end
        else sel = 1;
      end else if (u && wb_write_reg && wb_rd == rs) sel = 2;
      else if (u && long_done && m_busy && m_rd == rs) sel = 3;
      e_fwd[2*i +: 2] = 2'(sel);
      if (u && m_busy && m_rd == rs) raw = 1;
    end
    e_stall = mem_stall || lu ||
              (m_busy && ex_valid && ((raw && !long_done) ||
                                     (ex_write_reg && ex_rd == m_rd && m_rd != 0) ||
                                     (ex_long && !long_done)));
  endtask

  task automatic model_clock();
    if (ex_valid && ex_long && !e_stall) begin
      m_busy = 1; m_rd = ex_rd; m_cnt = 0;
    end else if (m_busy) begin
      if (long_done) begin
        m_busy = 0; m_rd = '0; m_cnt = 0;
      end else if (m_cnt < LT) begin
        m_cnt++;
        if (m_cnt == LT) m_to = 1;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    ex_valid = 1; ex_long = 1; ex_rd = 5'd6; ex_rs = {5'd3, 5'd3}; ex_rs_used = 2'b11;
    mem_rd = 5'd3; mem_write_reg = 1; mem_read_mem = 1;
    #2;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL reset_load_use stall got %b exp 1", stall); end
    tests++; if (fwd_sel !== 4'b1010) begin fails++; $display("FAIL reset_fwd_lu got %b exp 1010", fwd_sel); end
    mem_read_mem = 0; mem_stall = 1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL reset_mem_stall got %b exp 1", stall); end
    tests++; if (fwd_sel !== 4'b0101) begin fails++; $display("FAIL reset_fwd_mem got %b exp 0101", fwd_sel); end
    mem_stall = 0;
    next_cycle();
    next_cycle();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_low got %b exp 0", stall); end
    tests++;
    if ({long_busy, busy_rd, long_timeout} !== 7'b0) begin
      fails++; $display("FAIL reset_status got busy=%b rd=%0d to=%b exp 0/0/0", long_busy, busy_rd, long_timeout);
    end
    clear_inputs();
    #1 rst = 1;
    next_cycle();
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    ex_valid = 1; ex_rs = {5'd3, 5'd3}; ex_rs_used = 2'b11;
    mem_rd = 5'd3; mem_write_reg = 1; wb_rd = 5'd3; wb_write_reg = 1;
    #1;
    tests++; if (fwd_sel !== 4'b0101) begin fails++; $display("FAIL fwd_exmem_prio got %b exp 0101", fwd_sel); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fwd_exmem_stall got %b exp 0", stall); end
    mem_write_reg = 0;
    #1;
    tests++; if (fwd_sel !== 4'b1010) begin fails++; $display("FAIL fwd_memwb got %b exp 1010", fwd_sel); end
    ex_rs_used = 2'b10; mem_write_reg = 1; mem_rd = 5'd4; ex_rs = {5'd4, 5'd3};
    #1;
    tests++; if (fwd_sel !== 4'b0100) begin fails++; $display("FAIL fwd_unused_op got %b exp 0100", fwd_sel); end
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_valid = 1; ex_rs = {5'd0, 5'd5}; ex_rs_used = 2'b01;
    mem_rd = 5'd5; mem_write_reg = 1; mem_read_mem = 1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall got %b exp 1", stall); end
    tests++; if (fwd_sel[1:0] !== 2'd2) begin fails++; $display("FAIL load_use_sel got %0d exp 2", fwd_sel[1:0]); end
    next_cycle();
    mem_write_reg = 0; mem_read_mem = 0; mem_rd = '0; wb_rd = 5'd5; wb_write_reg = 1;
    #1;
    tests++; if (fwd_sel[1:0] !== 2'd2) begin fails++; $display("FAIL load_use_after_sel got %0d exp 2", fwd_sel[1:0]); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_after_stall got %b exp 0", stall); end
    next_cycle();
  endtask

  task automatic test_long_raw();
    clear_inputs();
    ex_valid = 1; ex_long = 1; ex_write_reg = 1; ex_rd = 5'd7;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL long_issue_stall got %b exp 0", stall); end
    next_cycle();
    clear_inputs();
    ex_valid = 1; ex_write_reg = 1; ex_rd = 5'd8; ex_rs = {5'd0, 5'd7}; ex_rs_used = 2'b01;
    #1;
    tests++;
    if (long_busy !== 1'b1 || busy_rd !== 5'd7) begin
      fails++; $display("FAIL long_busy_state got busy=%b rd=%0d exp 1/7", long_busy, busy_rd);
    end
    for (int k = 0; k < 3; k++) begin
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL long_raw_stall[%0d] got %b exp 1", k, stall); end
      next_cycle();
    end
    long_done = 1;
    #1;
    tests++; if (fwd_sel[1:0] !== 2'd3) begin fails++; $display("FAIL long_done_sel got %0d exp 3", fwd_sel[1:0]); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL long_done_stall got %b exp 0", stall); end
    next_cycle();
    clear_inputs();
    #1;
    tests++;
    if (long_busy !== 1'b0 || busy_rd !== 5'd0) begin
      fails++; $display("FAIL long_retire got busy=%b rd=%0d exp 0/0", long_busy, busy_rd);
    end
  endtask

  task automatic test_coincide();
    clear_inputs();
    ex_valid = 1; ex_long = 1; ex_write_reg = 1; ex_rd = 5'd4;
    next_cycle();
    clear_inputs();
    repeat (40) next_cycle();
    long_done = 1; ex_valid = 1; ex_long = 1; ex_write_reg = 1; ex_rd = 5'd9;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL coincide_stall got %b exp 0", stall); end
    next_cycle();
    clear_inputs();
    #1;
    tests++;
    if (long_busy !== 1'b1 || busy_rd !== 5'd9) begin
      fails++; $display("FAIL coincide_state got busy=%b rd=%0d exp 1/9", long_busy, busy_rd);
    end
    repeat (63) next_cycle();
    tests++; if (long_timeout !== 1'b0) begin fails++; $display("FAIL coincide_cnt_restart got %b exp 0", long_timeout); end
    next_cycle();
    tests++; if (long_timeout !== 1'b1) begin fails++; $display("FAIL coincide_timeout got %b exp 1", long_timeout); end
  endtask

  task automatic test_timeout_reset();
    do_reset();
    ex_valid = 1; ex_long = 1; ex_write_reg = 1; ex_rd = 5'd12;
    next_cycle();
    clear_inputs();
    mem_stall = 1;
    repeat (63) next_cycle();
    tests++; if (long_timeout !== 1'b0) begin fails++; $display("FAIL timeout_early got %b exp 0", long_timeout); end
    next_cycle();
    tests++; if (long_timeout !== 1'b1) begin fails++; $display("FAIL timeout_set got %b exp 1", long_timeout); end
    mem_stall = 0;
    repeat (5) next_cycle();
    tests++;
    if (long_timeout !== 1'b1 || long_busy !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky got to=%b busy=%b exp 1/1", long_timeout, long_busy);
    end
    #1 rst = 0;
    #1;
    tests++;
    if ({long_busy, busy_rd, long_timeout} !== 7'b0) begin
      fails++; $display("FAIL async_reset got busy=%b rd=%0d to=%b exp 0/0/0", long_busy, busy_rd, long_timeout);
    end
    do_reset();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    ex_valid = 1; ex_rs = '0; ex_rs_used = 2'b11;
    mem_rd = '0; mem_write_reg = 1; mem_read_mem = 1; wb_rd = '0; wb_write_reg = 1;
    #1;
    tests++; if (fwd_sel !== 4'b0000) begin fails++; $display("FAIL zero_fwd got %b exp 0000", fwd_sel); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zero_stall got %b exp 0", stall); end
    clear_inputs();
    ex_valid = 1; ex_long = 1; ex_write_reg = 1; ex_rd = '0;
    next_cycle();
    clear_inputs();
    ex_valid = 1; ex_write_reg = 1; ex_rd = '0; ex_rs = '0; ex_rs_used = 2'b11;
    #1;
    tests++;
    if (long_busy !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL zero_busy_nostall got busy=%b stall=%b exp 1/0", long_busy, stall);
    end
    clear_inputs();
    long_done = 1;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ex_valid      = ($urandom_range(0, 7) != 0);
      ex_rs[4:0]    = 5'($urandom_range(0, 3));
      ex_rs[9:5]    = 5'($urandom_range(0, 3));
      ex_rs_used    = 2'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_write_reg  = 1'($urandom_range(0, 1));
      ex_long       = ($urandom_range(0, 3) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_write_reg = 1'($urandom_range(0, 1));
      mem_read_mem  = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 3));
      wb_write_reg  = 1'($urandom_range(0, 1));
      long_done     = ($urandom_range(0, 5) == 0);
      mem_stall     = ($urandom_range(0, 7) == 0);
      #1;
      model_comb();
      tests++; if (fwd_sel !== e_fwd) begin fails++; $display("FAIL rand_fwd cyc %0d got %b exp %b", c, fwd_sel, e_fwd); end
      tests++; if (stall !== e_stall) begin fails++; $display("FAIL rand_stall cyc %0d got %b exp %b", c, stall, e_stall); end
      tests++; if (long_busy !== m_busy) begin fails++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, long_busy, m_busy); end
      tests++; if (busy_rd !== m_rd) begin fails++; $display("FAIL rand_busy_rd cyc %0d got %0d exp %0d", c, busy_rd, m_rd); end
      tests++; if (long_timeout !== m_to) begin fails++; $display("FAIL rand_timeout cyc %0d got %b exp %b", c, long_timeout, m_to); end
      model_clock();
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_long_raw();
    test_coincide();
    test_timeout_reset();
    test_zero_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
